// File: rtl/exc_arbiter.sv
// Exception arbiter: takes 4 level requests, hands one to the coprocessor, then grants it.
// Selection is fixed priority by default; define EXC_ARB_RR_EN for round-robin selection.
module exc_arbiter #(
  parameter int ADDR_W = 32,
  parameter int TMO    = 15
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [3:0]          REQ,
  input  logic [15:0]         REQ_CODE,
  input  logic [4*ADDR_W-1:0] REQ_EPC,
  input  logic [3:0]          REQ_BD,
  input  logic [ADDR_W-1:0]   IRQ_EPC,
  input  logic                IRQ_BD,
  input  logic                EXC_OCCUR,
  output logic                EXC_SET,
  output logic [3:0]          EXC_CODE,
  output logic [ADDR_W-1:0]   EXC_EPC,
  output logic                EXC_BD,
  output logic                EXC_ACK,
  output logic [3:0]          GNT,
  output logic                BUSY,
  output logic                TOERR
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SET  = 3'd1,
    S_WAIT = 3'd2,
    S_ACK  = 3'd3,
    S_HOLD = 3'd4
  } state_t;

  // Timeout fires on the WAIT cycle where the counter would reach TMO.
  localparam logic [3:0] TMO_LAST = 4'(TMO - 1);

  state_t     state;
  logic [3:0] cnt;
  logic [1:0] idx;
  logic       irq_flag;
  logic [1:0] sel_idx;
  logic       sel_vld;

  function automatic logic [2:0] pick_fixed(input logic [3:0] req);
    logic [2:0] r;
    r = 3'b000;
    if (req[0])      r = 3'b100;
    else if (req[1]) r = 3'b101;
    else if (req[2]) r = 3'b110;
    else if (req[3]) r = 3'b111;
    return r;
  endfunction

`ifdef EXC_ARB_RR_EN
  logic [1:0] rr_ptr;

  // Scan from farthest to nearest so the source closest to the pointer wins.
  function automatic logic [2:0] pick_rr(input logic [3:0] req, input logic [1:0] ptr);
    logic [2:0] r;
    logic [1:0] c;
    r = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      c = ptr + 2'(k);
      if (req[c]) r = {1'b1, c};
    end
    return r;
  endfunction

  always_comb begin
    {sel_vld, sel_idx} = pick_rr(REQ, rr_ptr);
  end
`else
  always_comb begin
    {sel_vld, sel_idx} = pick_fixed(REQ);
  end
`endif

  assign BUSY = (state != S_IDLE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      idx      <= 2'd0;
      irq_flag <= 1'b0;
      EXC_SET  <= 1'b0;
      EXC_ACK  <= 1'b0;
      GNT      <= 4'b0000;
      TOERR    <= 1'b0;
      EXC_CODE <= 4'd0;
      EXC_EPC  <= '0;
      EXC_BD   <= 1'b0;
`ifdef EXC_ARB_RR_EN
      rr_ptr   <= 2'd0;
`endif
    end else begin
      EXC_SET <= 1'b0;
      EXC_ACK <= 1'b0;
      GNT     <= 4'b0000;
      TOERR   <= 1'b0;
      case (state)
        S_IDLE: begin
          // A coprocessor-raised interrupt bypasses SET/WAIT and is acked directly.
          if (EXC_OCCUR) begin
            irq_flag <= 1'b1;
            EXC_CODE <= 4'd0;
            EXC_EPC  <= IRQ_EPC;
            EXC_BD   <= IRQ_BD;
            EXC_ACK  <= 1'b1;
            state    <= S_ACK;
          end else if (sel_vld) begin
            irq_flag <= 1'b0;
            idx      <= sel_idx;
            EXC_CODE <= REQ_CODE[{sel_idx, 2'b00} +: 4];
            EXC_EPC  <= REQ_EPC[ADDR_W*sel_idx +: ADDR_W];
            EXC_BD   <= REQ_BD[sel_idx];
            EXC_SET  <= 1'b1;
            state    <= S_SET;
          end
        end
        S_SET: begin
          cnt   <= 4'd0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (EXC_OCCUR) begin
            EXC_ACK <= 1'b1;
            GNT     <= irq_flag ? 4'b0000 : (4'b0001 << idx);
`ifdef EXC_ARB_RR_EN
            if (!irq_flag) rr_ptr <= idx + 2'd1;
`endif
            state   <= S_ACK;
          end else if (cnt == TMO_LAST) begin
            TOERR <= 1'b1;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_ACK:   state <= S_HOLD;
        S_HOLD:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exc_arbiter.sv
// Directed bench for exc_arbiter: reset, single request, priority, interrupt bypass,
// timeout and asynchronous reset, with hand-computed expected values.
module tb_exc_arbiter;

  localparam int ADDR_W = 32;

  logic                CLK;
  logic                RST;
  logic [3:0]          REQ;
  logic [15:0]         REQ_CODE;
  logic [4*ADDR_W-1:0] REQ_EPC;
  logic [3:0]          REQ_BD;
  logic [ADDR_W-1:0]   IRQ_EPC;
  logic                IRQ_BD;
  logic                EXC_OCCUR;
  logic                EXC_SET;
  logic [3:0]          EXC_CODE;
  logic [ADDR_W-1:0]   EXC_EPC;
  logic                EXC_BD;
  logic                EXC_ACK;
  logic [3:0]          GNT;
  logic                BUSY;
  logic                TOERR;

  int checks = 0;
  int errors = 0;

  exc_arbiter #(.ADDR_W(ADDR_W), .TMO(15)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_CODE(REQ_CODE), .REQ_EPC(REQ_EPC),
    .REQ_BD(REQ_BD), .IRQ_EPC(IRQ_EPC), .IRQ_BD(IRQ_BD), .EXC_OCCUR(EXC_OCCUR),
    .EXC_SET(EXC_SET), .EXC_CODE(EXC_CODE), .EXC_EPC(EXC_EPC), .EXC_BD(EXC_BD),
    .EXC_ACK(EXC_ACK), .GNT(GNT), .BUSY(BUSY), .TOERR(TOERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; REQ = 4'b0; EXC_OCCUR = 1'b0;
    REQ_CODE = {4'h3, 4'h2, 4'h1, 4'hA};
    REQ_EPC  = {32'h500, 32'h400, 32'h300, 32'h200};
    REQ_BD   = 4'b1010;
    IRQ_EPC  = 32'hDEAD_BEE0; IRQ_BD = 1'b1;
    tick(); tick();
    checks++;
    if ({EXC_SET, EXC_ACK, GNT, BUSY, TOERR} !== 8'h00) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 00000000", {EXC_SET, EXC_ACK, GNT, BUSY, TOERR});
    end
    checks++;
    if ({EXC_CODE, EXC_BD, EXC_EPC} !== 37'h0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", {EXC_CODE, EXC_BD, EXC_EPC});
    end
    RST = 1'b0;
    tick();
    checks++;
    if ({EXC_SET, BUSY} !== 2'b00) begin
      errors++; $display("FAIL idle_no_req: got %b expected 00", {EXC_SET, BUSY});
    end
  endtask

  task automatic test_single();
    REQ = 4'b0001;
    tick();
    checks++;
    if ({EXC_SET, BUSY, EXC_CODE, EXC_BD, EXC_EPC} !== {1'b1, 1'b1, 4'hA, 1'b0, 32'h200}) begin
      errors++; $display("FAIL single_set: got set=%b busy=%b code=%h bd=%b epc=%h expected 1 1 a 0 00000200",
                         EXC_SET, BUSY, EXC_CODE, EXC_BD, EXC_EPC);
    end
    REQ_CODE[3:0] = 4'h5;
    REQ_EPC[31:0] = 32'h777;
    tick();
    checks++;
    if ({EXC_SET, EXC_CODE, EXC_EPC} !== {1'b0, 4'hA, 32'h200}) begin
      errors++; $display("FAIL single_latch_hold: got set=%b code=%h epc=%h expected 0 a 00000200",
                         EXC_SET, EXC_CODE, EXC_EPC);
    end
    EXC_OCCUR = 1'b1;
    tick();
    EXC_OCCUR = 1'b0;
    checks++;
    if ({EXC_ACK, GNT, EXC_CODE, EXC_EPC} !== {1'b1, 4'b0001, 4'hA, 32'h200}) begin
      errors++; $display("FAIL single_ack: got ack=%b gnt=%b code=%h epc=%h expected 1 0001 a 00000200",
                         EXC_ACK, GNT, EXC_CODE, EXC_EPC);
    end
    REQ = 4'b0000;
    REQ_CODE[3:0] = 4'hA;
    REQ_EPC[31:0] = 32'h200;
    tick();
    checks++;
    if ({EXC_ACK, GNT, BUSY} !== 6'b0_0000_1) begin
      errors++; $display("FAIL single_hold: got ack=%b gnt=%b busy=%b expected 0 0000 1", EXC_ACK, GNT, BUSY);
    end
    tick();
    checks++;
    if (BUSY !== 1'b0) begin
      errors++; $display("FAIL single_idle_busy: got %b expected 0", BUSY);
    end
  endtask

  task automatic test_priority();
    REQ = 4'b1010;
    tick();
    checks++;
    if ({EXC_SET, EXC_CODE, EXC_BD, EXC_EPC} !== {1'b1, 4'h1, 1'b1, 32'h300}) begin
      errors++; $display("FAIL prio_first_set: got set=%b code=%h bd=%b epc=%h expected 1 1 1 00000300",
                         EXC_SET, EXC_CODE, EXC_BD, EXC_EPC);
    end
    tick();
    EXC_OCCUR = 1'b1;
    tick();
    EXC_OCCUR = 1'b0;
    checks++;
    if ({EXC_ACK, GNT} !== 5'b1_0010) begin
      errors++; $display("FAIL prio_first_gnt: got ack=%b gnt=%b expected 1 0010", EXC_ACK, GNT);
    end
    REQ = 4'b1000;
    tick(); tick();
    checks++;
    if ({BUSY, EXC_SET} !== 2'b00) begin
      errors++; $display("FAIL prio_gap_idle: got busy=%b set=%b expected 0 0", BUSY, EXC_SET);
    end
    tick();
    checks++;
    if ({EXC_SET, EXC_CODE, EXC_EPC} !== {1'b1, 4'h3, 32'h500}) begin
      errors++; $display("FAIL prio_second_set: got set=%b code=%h epc=%h expected 1 3 00000500",
                         EXC_SET, EXC_CODE, EXC_EPC);
    end
    tick();
    EXC_OCCUR = 1'b1;
    tick();
    EXC_OCCUR = 1'b0;
    checks++;
    if ({EXC_ACK, GNT} !== 5'b1_1000) begin
      errors++; $display("FAIL prio_second_gnt: got ack=%b gnt=%b expected 1 1000", EXC_ACK, GNT);
    end
    REQ = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_rr_pointer();
    logic [3:0] exp_gnt;
    REQ = 4'b0010;
    tick(); tick();
    EXC_OCCUR = 1'b1;
    tick();
    EXC_OCCUR = 1'b0;
    checks++;
    if (GNT !== 4'b0010) begin
      errors++; $display("FAIL rr_prime_gnt: got %b expected 0010", GNT);
    end
    REQ = 4'b0000;
    tick(); tick();
    REQ = 4'b0011;
    tick();
    checks++;
    if ({EXC_SET, EXC_CODE} !== {1'b1, 4'hA}) begin
      errors++; $display("FAIL rr_wrap_set: got set=%b code=%h expected 1 a", EXC_SET, EXC_CODE);
    end
    tick();
    EXC_OCCUR = 1'b1;
    tick();
    EXC_OCCUR = 1'b0;
    checks++;
    if (GNT !== 4'b0001) begin
      errors++; $display("FAIL rr_wrap_gnt: got %b expected 0001", GNT);
    end
    tick(); tick();
`ifdef EXC_ARB_RR_EN
    exp_gnt = 4'b0010;
`else
    exp_gnt = 4'b0001;
`endif
    tick(); tick();
    EXC_OCCUR = 1'b1;
    tick();
    EXC_OCCUR = 1'b0;
    checks++;
    if (GNT !== exp_gnt) begin
      errors++; $display("FAIL sel_policy_gnt: got %b expected %b", GNT, exp_gnt);
    end
    REQ = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_irq();
    EXC_OCCUR = 1'b1;
    REQ = 4'b0100;
    tick();
    EXC_OCCUR = 1'b0;
    checks++;
    if ({EXC_ACK, GNT, EXC_SET, EXC_CODE, EXC_BD, EXC_EPC} !== {1'b1, 4'b0000, 1'b0, 4'h0, 1'b1, 32'hDEAD_BEE0}) begin
      errors++; $display("FAIL irq_ack: got ack=%b gnt=%b set=%b code=%h bd=%b epc=%h expected 1 0000 0 0 1 deadbee0",
                         EXC_ACK, GNT, EXC_SET, EXC_CODE, EXC_BD, EXC_EPC);
    end
    tick();
    checks++;
    if ({EXC_ACK, BUSY} !== 2'b01) begin
      errors++; $display("FAIL irq_hold: got ack=%b busy=%b expected 0 1", EXC_ACK, BUSY);
    end
    tick(); tick();
    checks++;
    if ({EXC_SET, EXC_CODE, EXC_BD, EXC_EPC} !== {1'b1, 4'h2, 1'b0, 32'h400}) begin
      errors++; $display("FAIL irq_then_src2_set: got set=%b code=%h bd=%b epc=%h expected 1 2 0 00000400",
                         EXC_SET, EXC_CODE, EXC_BD, EXC_EPC);
    end
    tick();
    EXC_OCCUR = 1'b1;
    tick();
    EXC_OCCUR = 1'b0;
    checks++;
    if ({EXC_ACK, GNT} !== 5'b1_0100) begin
      errors++; $display("FAIL irq_then_src2_gnt: got ack=%b gnt=%b expected 1 0100", EXC_ACK, GNT);
    end
    REQ = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    REQ = 4'b0001;
    tick();
    checks++;
    if (EXC_SET !== 1'b1) begin
      errors++; $display("FAIL tmo_first_set: got %b expected 1", EXC_SET);
    end
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (TOERR !== 1'b0 || EXC_ACK !== 1'b0 || BUSY !== 1'b1 || EXC_SET !== 1'b0) early++;
    end
    checks++;
    if (early !== 0) begin
      errors++; $display("FAIL tmo_wait_window: got %0d bad cycles expected 0", early);
    end
    tick();
    checks++;
    if ({TOERR, BUSY, EXC_ACK, GNT} !== 7'b1_0_0_0000) begin
      errors++; $display("FAIL tmo_pulse: got toerr=%b busy=%b ack=%b gnt=%b expected 1 0 0 0000",
                         TOERR, BUSY, EXC_ACK, GNT);
    end
    tick();
    checks++;
    if ({EXC_SET, TOERR, EXC_CODE} !== {1'b1, 1'b0, 4'hA}) begin
      errors++; $display("FAIL tmo_rearb_set: got set=%b toerr=%b code=%h expected 1 0 a", EXC_SET, TOERR, EXC_CODE);
    end
    tick();
    EXC_OCCUR = 1'b1;
    tick();
    EXC_OCCUR = 1'b0;
    checks++;
    if ({EXC_ACK, GNT} !== 5'b1_0001) begin
      errors++; $display("FAIL tmo_rearb_gnt: got ack=%b gnt=%b expected 1 0001", EXC_ACK, GNT);
    end
    REQ = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_async_reset();
    REQ = 4'b0010;
    tick(); tick();
    #2;
    RST = 1'b1;
    #1;
    checks++;
    if ({EXC_SET, EXC_ACK, GNT, BUSY, TOERR, EXC_CODE, EXC_BD, EXC_EPC} !== 45'h0) begin
      errors++; $display("FAIL rst_in_wait: got busy=%b code=%h bd=%b epc=%h expected all 0",
                         BUSY, EXC_CODE, EXC_BD, EXC_EPC);
    end
    #1;
    RST = 1'b0;
    tick();
    checks++;
    if ({EXC_SET, EXC_CODE, EXC_EPC} !== {1'b1, 4'h1, 32'h300}) begin
      errors++; $display("FAIL rst_restart_set: got set=%b code=%h epc=%h expected 1 1 00000300",
                         EXC_SET, EXC_CODE, EXC_EPC);
    end
    tick();
    EXC_OCCUR = 1'b1;
    tick();
    EXC_OCCUR = 1'b0;
    checks++;
    if ({EXC_ACK, GNT} !== 5'b1_0010) begin
      errors++; $display("FAIL rst_pre_ack: got ack=%b gnt=%b expected 1 0010", EXC_ACK, GNT);
    end
    #2;
    RST = 1'b1;
    #1;
    checks++;
    if ({EXC_ACK, GNT, BUSY} !== 6'b0) begin
      errors++; $display("FAIL rst_in_ack: got ack=%b gnt=%b busy=%b expected 0 0000 0", EXC_ACK, GNT, BUSY);
    end
    #1;
    RST = 1'b0;
    tick();
    checks++;
    if (EXC_SET !== 1'b1) begin
      errors++; $display("FAIL rst_ack_restart: got %b expected 1", EXC_SET);
    end
    tick();
    EXC_OCCUR = 1'b1;
    tick();
    EXC_OCCUR = 1'b0;
    checks++;
    if (GNT !== 4'b0010) begin
      errors++; $display("FAIL rst_final_gnt: got %b expected 0010", GNT);
    end
    REQ = 4'b0000;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_rr_pointer();
    test_irq();
    test_timeout();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exc_arbiter.md
EXC_ARBITER -- requirements
Module: exc_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, width of exception return addresses.
REQ-002 SHALL have parameter TMO, default 15, maximum WAIT cycles before timeout (1..15).
REQ-003 SHALL have port CLK  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port REQ  input  4  exception request per source, level, held until GNT.
REQ-006 SHALL have port REQ_CODE  input  16  4-bit exception code per source; source i at [4i+3:4i].
REQ-007 SHALL have port REQ_EPC  input  4*ADDR_W  return address per source; source i at [ADDR_W*i +: ADDR_W].
REQ-008 SHALL have port REQ_BD  input  4  branch-delay flag per source.
REQ-009 SHALL have port IRQ_EPC  input  ADDR_W  current PC, used for coprocessor-raised interrupts.
REQ-010 SHALL have port IRQ_BD  input  1  branch-delay flag for IRQ_EPC.
REQ-011 SHALL have port EXC_OCCUR  input  1  coprocessor exception-pending flag.
REQ-012 SHALL have port EXC_SET  output  1  one-cycle exception raise to coprocessor.
REQ-013 SHALL have port EXC_CODE  output  4  code of the latched request.
REQ-014 SHALL have port EXC_EPC  output  ADDR_W  latched return address.
REQ-015 SHALL have port EXC_BD  output  1  latched branch-delay flag.
REQ-016 SHALL have port EXC_ACK  output  1  one-cycle acknowledge to coprocessor.
REQ-017 SHALL have port GNT  output  4  one-hot, one-cycle grant to the serviced source.
REQ-018 SHALL have port BUSY  output  1  high in every state except IDLE.
REQ-019 SHALL have port TOERR  output  1  one-cycle pulse on WAIT timeout.

Function
REQ-020 SHALL implement states IDLE, SET, WAIT, ACK, HOLD; all outputs registered or decoded from registered state only.
REQ-021 IDLE: EXC_OCCUR=1 SHALL take priority over REQ -> latch IRQ_EPC/IRQ_BD, code 0, internal flag -> ACK.
REQ-022 IDLE: else any REQ bit set SHALL select one source, latch its code/EPC/BD and index -> SET.
REQ-023 SET: EXC_SET=1 exactly one cycle -> WAIT; WAIT counter cleared.
REQ-024 WAIT: EXC_OCCUR=1 -> ACK; else counter increments; counter reaching TMO -> TOERR pulse next cycle, -> IDLE, no GNT, no ACK.
REQ-025 ACK: EXC_ACK=1 one cycle; GNT[idx]=1 same cycle unless internal flag set (GNT=0) -> HOLD.
REQ-026 HOLD: one idle cycle so requester drops REQ -> IDLE.
REQ-027 Latency: REQ rising while IDLE at edge n -> EXC_SET high cycle n+1; EXC_OCCUR seen at edge m in WAIT -> EXC_ACK/GNT cycle m+1.
REQ-028 EXC_CODE/EXC_EPC/EXC_BD SHALL hold latched values from SET through ACK; REQ changes after latch ignored.
REQ-029 REQ asserted outside IDLE SHALL wait; no request lost while held.
REQ-030 REQ deasserted before grant: already-latched request SHALL complete normally.
REQ-031 WAIT counter 4 bits, saturating never reached (TMO<=15); no wrap.

Reset
REQ-032 RST high SHALL immediately force IDLE, any phase, including mid-handshake.
REQ-033 Reset values: EXC_SET=0, EXC_ACK=0, GNT=0, BUSY=0, TOERR=0, EXC_CODE=0, EXC_EPC=0, EXC_BD=0, counter=0, round-robin pointer=0.

Configuration
REQ-034 Macro EXC_ARB_RR_EN defined: round-robin selection, search starts at (last granted index+1) mod 4; pointer updates only on GNT, not on timeout or internal ACK.
REQ-035 EXC_ARB_RR_EN undefined: fixed priority, index 0 highest, 3 lowest; no pointer register.

Verification
REQ-036 Single REQ=0001, code 4'hA, EPC 'h200; EXC_OCCUR 2 cycles after EXC_SET -> EXC_SET cycle 1, EXC_CODE=A, EXC_EPC='h200, EXC_ACK+GNT=0001 together, BUSY 0 after HOLD.
REQ-037 REQ=1010 held, fixed priority -> GNT 0010 then GNT 1000; RR build with pointer after index 1 and REQ=0011 -> GNT 0001 first.
REQ-038 EXC_OCCUR=1 in IDLE with REQ=0100 same cycle -> EXC_ACK with EXC_EPC=IRQ_EPC, GNT=0000; then source 2 serviced via SET.
REQ-039 No EXC_OCCUR after EXC_SET, TMO=15 -> TOERR pulse 16 cycles after EXC_SET, no EXC_ACK, REQ still high -> re-arbitrated, EXC_SET again.
REQ-040 RST pulsed while in WAIT -> all outputs 0 same cycle asynchronously, state IDLE, next held REQ restarts at SET.
